// File: rtl/zork_pkg.sv
// Shared encodings for the player navigation block:
// move directions, keypad codes and nav FSM states.
package zork_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_NONE  = 3'd4
  } dir_t;

  localparam logic [3:0] KEY_UP    = 4'h2;
  localparam logic [3:0] KEY_DOWN  = 4'h8;
  localparam logic [3:0] KEY_RIGHT = 4'h6;
  localparam logic [3:0] KEY_LEFT  = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_CHECK = 2'd2
  } nav_state_t;

  function automatic dir_t decode_key(input logic [3:0] key);
    dir_t d;
    d = DIR_NONE;
    unique case (1'b1)
      (key == KEY_UP):    d = DIR_UP;
      (key == KEY_DOWN):  d = DIR_DOWN;
      (key == KEY_RIGHT): d = DIR_RIGHT;
      (key == KEY_LEFT):  d = DIR_LEFT;
      default:            d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Keypad edge detect with hold-to-repeat; emits a
// registered one-cycle request plus its direction.
module key_repeat
  import zork_pkg::*;
#(
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [3:0] key_in,
  input  logic       enable_move,
  output dir_t       dir_o,
  output logic       req_o
);

  localparam int CW =
    (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_MAX =
    CW'(REPEAT_CYCLES - 1);

  logic [1:0]    en_sync;
  dir_t          dir;
  dir_t          prev_dir;
  logic [CW-1:0] hold_cnt;
  logic          changed;
  logic          repeat_hit;
  logic          req;

  assign dir        = decode_key(key_in);
  assign changed    = (dir != prev_dir);
  assign repeat_hit = (hold_cnt == HOLD_MAX);
  assign req        = en_sync[1] && (dir != DIR_NONE)
                   && (changed || repeat_hit);

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      en_sync <= 2'b00;
    end else begin
      en_sync <= {en_sync[0], enable_move};
    end
  end

  // Counter restarts on every terminal count so repeats stay periodic.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      prev_dir <= DIR_NONE;
      hold_cnt <= '0;
      req_o    <= 1'b0;
      dir_o    <= DIR_NONE;
    end else begin
      prev_dir <= dir;
      req_o    <= req;
      dir_o    <= dir;
      if (changed || (dir == DIR_NONE) || repeat_hit) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_nav.sv
// Grid player position tracker: keypad moves are checked
// against grid edges and the map ROM wall flag.
module player_nav
  import zork_pkg::*;
#(
  parameter int X_BITS        = 3,
  parameter int Y_BITS        = 2,
  parameter int START_X       = (1 << X_BITS) - 1,
  parameter int START_Y       = (1 << Y_BITS) - 1,
  parameter int WRAP_EN       = 0,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic                     clk_50MHz_i,
  input  logic                     rst_async_la_i,
  input  logic [3:0]               key_in,
  input  logic                     enable_move,
  input  logic                     wall_i,
  output logic [X_BITS+Y_BITS-1:0] query_addr_o,
  output logic [X_BITS+Y_BITS-1:0] address,
  output logic                     moved_o,
  output logic                     bump_o,
  output logic [15:0]              move_count_o
);

  dir_t              req_dir;
  logic              req;
  nav_state_t        state_q;
  nav_state_t        state_d;
  logic [X_BITS-1:0] posx;
  logic [Y_BITS-1:0] posy;
  logic [X_BITS-1:0] tgt_x;
  logic [Y_BITS-1:0] tgt_y;
  logic [X_BITS:0]   nx;
  logic [Y_BITS:0]   ny;
  logic              off_grid;
  logic              accept;
  logic              commit;
  logic              reject;

  key_repeat #(
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_key_repeat (
    .clk_50MHz_i   (clk_50MHz_i),
    .rst_async_la_i(rst_async_la_i),
    .key_in        (key_in),
    .enable_move   (enable_move),
    .dir_o         (req_dir),
    .req_o         (req)
  );

  // One extra MSB flags leaving the grid; dropping it gives the wrap.
  always_comb begin
    nx = {1'b0, posx};
    ny = {1'b0, posy};
    unique case (1'b1)
      (req_dir == DIR_UP):
        ny = {1'b0, posy} - {{Y_BITS{1'b0}}, 1'b1};
      (req_dir == DIR_DOWN):
        ny = {1'b0, posy} + {{Y_BITS{1'b0}}, 1'b1};
      (req_dir == DIR_RIGHT):
        nx = {1'b0, posx} + {{X_BITS{1'b0}}, 1'b1};
      (req_dir == DIR_LEFT):
        nx = {1'b0, posx} - {{X_BITS{1'b0}}, 1'b1};
      default: ;
    endcase
    off_grid = (WRAP_EN == 0) && (nx[X_BITS] || ny[Y_BITS]);
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req && !off_grid) state_d = ST_QUERY;
      ST_QUERY: state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    query_addr_o = {posx, posy};
    accept       = 1'b0;
    commit       = 1'b0;
    reject       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = req && !off_grid;
        reject = req && off_grid;
      end
      ST_QUERY: begin
        query_addr_o = {tgt_x, tgt_y};
      end
      ST_CHECK: begin
        query_addr_o = {tgt_x, tgt_y};
        commit       = !wall_i;
        reject       = wall_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      posx         <= X_BITS'(START_X);
      posy         <= Y_BITS'(START_Y);
      tgt_x        <= X_BITS'(START_X);
      tgt_y        <= Y_BITS'(START_Y);
      moved_o      <= 1'b0;
      bump_o       <= 1'b0;
      move_count_o <= 16'h0000;
    end else begin
      moved_o <= commit;
      bump_o  <= reject;
      if (accept) begin
        tgt_x <= nx[X_BITS-1:0];
        tgt_y <= ny[Y_BITS-1:0];
      end
      if (commit) begin
        posx <= tgt_x;
        posy <= tgt_y;
        if (move_count_o != 16'hFFFF) begin
          move_count_o <= move_count_o + 16'h0001;
        end
      end
    end
  end

  assign address = {posx, posy};

endmodule

// File: doc/player_nav.md
PLAYER_NAV -- requirements
Module: player_nav

Interface
REQ-001 Parameter X_BITS, default 3: column coordinate width; grid columns 0..2^X_BITS-1.
REQ-002 Parameter Y_BITS, default 2: row coordinate width; grid rows 0..2^Y_BITS-1.
REQ-003 Parameter START_X, default 2^X_BITS-1; parameter START_Y, default 2^Y_BITS-1: reset position.
REQ-004 Parameter WRAP_EN, default 0: 1 = edges wrap toroidally, 0 = edges block.
REQ-005 Parameter REPEAT_CYCLES, default 12_500_000: hold time between auto-repeat moves (250 ms).
REQ-006 clk_50MHz_i  in  1  system clock, all logic on rising edge.
REQ-007 rst_async_la_i  in  1  reset, asynchronous, active-low.
REQ-008 key_in  in  4  keypad code: 4'h2 UP, 4'h8 DOWN, 4'h6 RIGHT, 4'h4 LEFT, other = NONE.
REQ-009 enable_move  in  1  asynchronous move enable.
REQ-010 wall_i  in  1  blocked flag for query_addr_o, valid one cycle after query_addr_o is presented.
REQ-011 query_addr_o  out  X_BITS+Y_BITS  target cell {x,y} sent to the map ROM.
REQ-012 address  out  X_BITS+Y_BITS  current position {posx,posy}.
REQ-013 moved_o  out  1  one-cycle pulse on each committed move.
REQ-014 bump_o  out  1  one-cycle pulse on each rejected move (edge or wall).
REQ-015 move_count_o  out  16  committed move count.

Function
REQ-016 enable_move SHALL pass through a two-flop synchroniser before use.
REQ-017 A move request SHALL be raised when: synced enable=1, decoded dir != NONE, and either dir differs from the previous cycle's dir or the hold counter reaches REPEAT_CYCLES-1.
REQ-018 Hold counter SHALL clear on any dir change, or when dir=NONE, and SHALL restart from 0 after each repeat request.
REQ-019 FSM states: IDLE, QUERY, CHECK; IDLE->QUERY on request, QUERY->CHECK unconditionally, CHECK->IDLE unconditionally.
REQ-020 In IDLE on request, the target SHALL be computed and registered; off-grid target with WRAP_EN=0 SHALL pulse bump_o next cycle and stay IDLE.
REQ-021 With WRAP_EN=1, x=max+1 SHALL become 0, x=0-1 SHALL become max; likewise y (modulo 2^BITS).
REQ-022 query_addr_o SHALL hold the registered target in QUERY and CHECK; otherwise it SHALL equal address.
REQ-023 In CHECK, wall_i=0 SHALL update address to target and pulse moved_o; wall_i=1 SHALL pulse bump_o, leaving the position unchanged.
REQ-024 Latency: request at edge N -> address/moved_o updated at edge N+3; max throughput is one move per 3 cycles.
REQ-025 Requests arising outside IDLE SHALL be dropped, not queued; key or enable changes during QUERY/CHECK SHALL NOT alter the in-flight target.
REQ-026 move_count_o SHALL increment on each moved_o and saturate at 16'hFFFF.
REQ-027 moved_o and bump_o SHALL never assert in the same cycle.

Reset
REQ-028 On rst_async_la_i=0: address={START_X,START_Y}, FSM=IDLE, moved_o=0, bump_o=0, move_count_o=0, hold counter=0, synchroniser=0, previous dir=NONE.
REQ-029 Reset mid-operation SHALL abort the in-flight move with no moved_o/bump_o pulse.

Structure
REQ-030 Shared package zork_pkg SHALL hold direction encoding (UP=0, DOWN=1, RIGHT=2, LEFT=3, NONE=4), keypad codes and FSM state encoding.
REQ-031 Edge/auto-repeat logic SHALL be one sub-module, key_repeat, outputting dir and a request pulse.

Verification (X_BITS=3, Y_BITS=2, REPEAT_CYCLES=4, wall_i=0 unless stated)
REQ-032 Release reset, hold key_in=4'h2 one press -> address goes 5'b111_11 -> 5'b111_10 three cycles after request, moved_o one pulse, count=1.
REQ-033 At (7,3) press 4'h6, WRAP_EN=0 -> bump_o pulse, address unchanged; WRAP_EN=1 -> address 5'b000_11.
REQ-034 From (7,3) press 4'h4 with wall_i=1 in CHECK -> bump_o pulse, address 5'b111_11, count unchanged.
REQ-035 Hold 4'h4 for 20 cycles from (7,3) -> repeat requests at 4-cycle hold intervals, one moved_o per request, no extra requests while FSM busy.
REQ-036 Assert reset during QUERY -> address 5'b111_11, count 0, no pulse; enable_move=0 -> no requests for any key.
